// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter for the execute stage: SLL, SRL, SRA and
// (optionally) ROR, with valid/ready handshakes on both sides.
// Optional feature macro: SHIFTER_ROTATE_EN (op 2'b11 = rotate right).
// When it is undefined, op 2'b11 is still accepted but returns zero,
// and no rotate wiring is built.
//
// Left shifts are done by bit-reversing the operand, shifting right and
// reversing back, so every layer is a right-shift mux. The log2(XLEN)
// layers are spread across STAGES register stages. Each stage holds
// valid, op, partial data, shift amount and tag. Bubbles collapse:
// a stage takes new content whenever it is empty or its current
// content moves on in the same cycle.
module shifter_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [XLEN-1:0]          in_a,
    input  logic [$clog2(XLEN)-1:0]  in_shamt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_h,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // First layer owned by stage s: ceil(SHW*s/STAGES)
    function automatic int layer_lo(input int s);
        return (SHW * s + STAGES - 1) / STAGES;
    endfunction

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

    // Per-stage state
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] load_vec;
    logic [STAGES-1:0] leave_vec;

    logic [XLEN-1:0]   data_reg  [STAGES];
    logic [1:0]        op_reg    [STAGES];
    logic [SHW-1:0]    shamt_reg [STAGES];
    logic [TAG_W-1:0]  tag_reg   [STAGES];

    // Values each stage would capture if it loads this cycle
    logic [XLEN-1:0]   data_next  [STAGES];
    logic [1:0]        op_next    [STAGES];
    logic [SHW-1:0]    shamt_next [STAGES];
    logic [TAG_W-1:0]  tag_next   [STAGES];

    // Advance logic: walk from the output back so each stage knows whether
    // its successor frees up a slot this cycle.
    always_comb begin
        load_vec  = '0;
        leave_vec = '0;
        leave_vec[STAGES-1] = valid_reg[STAGES-1] & out_ready;
        for (int s = STAGES - 1; s >= 1; s--) begin
            load_vec[s]    = valid_reg[s-1] & (~valid_reg[s] | leave_vec[s]);
            leave_vec[s-1] = load_vec[s];
        end
        in_ready    = ~flush & (~valid_reg[0] | leave_vec[0]);
        load_vec[0] = in_valid & in_ready;
        valid_next  = load_vec | (valid_reg & ~leave_vec);
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        localparam int LO = layer_lo(gi);
        localparam int HI = layer_lo(gi + 1);

        logic [XLEN-1:0]  src_data;
        logic [1:0]       src_op;
        logic [SHW-1:0]   src_shamt;
        logic [TAG_W-1:0] src_tag;
        logic [XLEN-1:0]  shifted;
        logic [XLEN-1:0]  res;

        if (gi == 0) begin : gen_src_in
            // Left shifts enter bit-reversed so the layers only shift right
            assign src_data  = (in_op == OP_SLL) ? bit_rev(in_a) : in_a;
            assign src_op    = in_op;
            assign src_shamt = in_shamt;
            assign src_tag   = in_tag;
        end else begin : gen_src_prev
            assign src_data  = data_reg[gi-1];
            assign src_op    = op_reg[gi-1];
            assign src_shamt = shamt_reg[gi-1];
            assign src_tag   = tag_reg[gi-1];
        end

        // Right-shift mux layers LO..HI-1; layer j shifts by 2^(SHW-1-j).
        // For SRA the MSB stays the sign at every layer, so it is the fill.
        always_comb begin
            logic [XLEN-1:0] cur;
            logic [XLEN-1:0] nxt;
            logic [SHW-1:0]  src_idx;
            logic            fill;
            int              amt;
            cur = src_data;
            for (int j = LO; j < HI; j++) begin
                amt  = 1 << (SHW - 1 - j);
                fill = (src_op == OP_SRA) & cur[XLEN-1];
                nxt  = cur;
                for (int i = 0; i < XLEN; i++) begin
                    src_idx = SHW'(i + amt);
                    if (i + amt < XLEN) begin
                        nxt[i] = cur[src_idx];
`ifdef SHIFTER_ROTATE_EN
                    end else if (src_op == OP_ROR) begin
                        nxt[i] = cur[src_idx];
`endif
                    end else begin
                        nxt[i] = fill;
                    end
                end
                if (src_shamt[SHW-1-j]) begin
                    cur = nxt;
                end
            end
            shifted = cur;
        end

        if (gi == STAGES - 1) begin : gen_post
            // Last stage undoes the left-shift reversal; without the rotate
            // build an op 11 result is forced to zero.
            always_comb begin
                res = shifted;
                if (src_op == OP_SLL) begin
                    res = bit_rev(shifted);
                end
`ifndef SHIFTER_ROTATE_EN
                if (src_op == OP_ROR) begin
                    res = '0;
                end
`endif
            end
        end else begin : gen_mid
            assign res = shifted;
        end

        assign data_next[gi]  = res;
        assign op_next[gi]    = src_op;
        assign shamt_next[gi] = src_shamt;
        assign tag_next[gi]   = src_tag;
    end

    // Valid bits: reset wins over flush, flush wins over any advance
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Payload registers load only when their stage advances; the output
    // stage payload is also cleared by reset so out_h/out_tag read zero.
    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (load_vec[s]) begin
                data_reg[s]  <= data_next[s];
                op_reg[s]    <= op_next[s];
                shamt_reg[s] <= shamt_next[s];
                tag_reg[s]   <= tag_next[s];
            end
        end
        if (rst) begin
            data_reg[STAGES-1] <= '0;
            tag_reg[STAGES-1]  <= '0;
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_h     = data_reg[STAGES-1];
    assign out_tag   = tag_reg[STAGES-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and random checks for shifter_pipe at XLEN=32, STAGES=2, TAG_W=5.
module tb_shifter_pipe;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'b00;
    logic [XLEN-1:0]   in_a = '0;
    logic [4:0]        in_shamt = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_h;
    logic [TAG_W-1:0]  out_tag;

    shifter_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_h     (out_h),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Values sampled at the falling edge before each rising edge
    logic              acc_q, xfer_q, ovalid_q, iready_q;
    logic [XLEN-1:0]   h_q;
    logic [TAG_W-1:0]  t_q;

    typedef struct {
        string            name;
        logic [1:0]       op;
        logic [31:0]      a;
        logic [4:0]       sh;
        logic [4:0]       tag;
        logic [31:0]      exp;
    } vec_t;

    typedef struct {
        logic [31:0] h;
        logic [4:0]  tag;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc_q    = in_valid && in_ready;
        xfer_q   = out_valid && out_ready;
        ovalid_q = out_valid;
        iready_q = in_ready;
        h_q      = out_h;
        t_q      = out_tag;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [4:0] sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return 32'($signed(a) >>> sh);
            default: return ROT ? ((a >> sh) | (a << (32 - int'(sh)))) : 32'h0;
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        in_valid  = 1'b1;
        in_op     = v.op;
        in_a      = v.a;
        in_shamt  = v.sh;
        in_tag    = v.tag;
        out_ready = 1'b1;
        acc_q     = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (acc_q) break;
        end
        check({v.name, "_accept"}, acc_q, 1);
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ovalid_q) begin
                lat = n;
                break;
            end
        end
        check({v.name, "_latency"}, lat, STAGES);
        check({v.name, "_h"}, h_q, v.exp);
        check({v.name, "_tag"}, t_q, v.tag);
        $display("vec %s op=%0d a=%h sh=%0d -> h=%h tag=%0d lat=%0d",
                 v.name, v.op, v.a, v.sh, h_q, t_q, lat);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_acc;
        int   n_seen;
        int   acc_cnt;
        int   cyc;
        bit   did_rst;
        exp_t e;

        vecs[0]  = '{"sll31",   2'd0, 32'h0000_0001, 5'd31, 5'd3,  32'h8000_0000};
        vecs[1]  = '{"sra4",    2'd2, 32'h8000_00F0, 5'd4,  5'd4,  32'hF800_000F};
        vecs[2]  = '{"srl4",    2'd1, 32'h8000_00F0, 5'd4,  5'd5,  32'h0800_000F};
        vecs[3]  = '{"sll0",    2'd0, 32'hDEAD_BEEF, 5'd0,  5'd6,  32'hDEAD_BEEF};
        vecs[4]  = '{"sra0",    2'd2, 32'h8000_0001, 5'd0,  5'd7,  32'h8000_0001};
        vecs[5]  = '{"srl31",   2'd1, 32'h8000_0000, 5'd31, 5'd8,  32'h0000_0001};
        vecs[6]  = '{"sra31",   2'd2, 32'h8000_0000, 5'd31, 5'd9,  32'hFFFF_FFFF};
        vecs[7]  = '{"sra_pos", 2'd2, 32'h7000_0000, 5'd28, 5'd10, 32'h0000_0007};
        vecs[8]  = '{"ror4",    2'd3, 32'h0000_00FF, 5'd4,  5'd11, ROT ? 32'hF000_000F : 32'h0};
        vecs[9]  = '{"ror0",    2'd3, 32'h1234_5678, 5'd0,  5'd12, ROT ? 32'h1234_5678 : 32'h0};
        vecs[10] = '{"sll16",   2'd0, 32'h0000_ABCD, 5'd16, 5'd13, 32'hABCD_0000};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", ovalid_q, 0);
        check("rst_out_h", h_q, 0);
        check("rst_out_tag", t_q, 0);
        check("rst_in_ready", iready_q, 1);

        // Single ops through the table
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back SRA then SRL
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd2; in_a = 32'h8000_00F0; in_shamt = 5'd4; in_tag = 5'd1;
        tick();
        check("b2b_acc0", acc_q, 1);
        in_op = 2'd1; in_tag = 5'd2;
        tick();
        check("b2b_acc1", acc_q, 1);
        in_valid = 1'b0;
        tick();
        check("b2b_v0", ovalid_q, 1);
        check("b2b_h0", h_q, 32'hF800_000F);
        check("b2b_t0", t_q, 1);
        tick();
        check("b2b_v1", ovalid_q, 1);
        check("b2b_h1", h_q, 32'h0800_000F);
        check("b2b_t1", t_q, 2);
        $display("b2b sra/srl done");
        tick();

        // Fill with out_ready low: exactly STAGES accepts
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'h1234_5678; in_shamt = 5'd8; in_tag = 5'd10;
        n_acc = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (acc_q) begin
                n_acc++;
                if (n_acc == 1) begin
                    in_op = 2'd1; in_tag = 5'd11;
                end else begin
                    in_op = 2'd2; in_a = 32'hF000_0000; in_tag = 5'd12;
                end
            end
        end
        check("stall_accepts", n_acc, STAGES);
        check("stall_in_ready", iready_q, 0);
        in_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("stall_valid", ovalid_q, 1);
            check("stall_h", h_q, 32'h3456_7800);
            check("stall_tag", t_q, 10);
        end
        // Release: simultaneous output and input on a full pipe
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd1; in_a = 32'h0000_00F0; in_shamt = 5'd4; in_tag = 5'd13;
        tick();
        check("drain_x0", xfer_q, 1);
        check("drain_h0", h_q, 32'h3456_7800);
        check("drain_t0", t_q, 10);
        check("drain_acc", acc_q, 1);
        in_valid = 1'b0;
        tick();
        check("drain_x1", xfer_q, 1);
        check("drain_h1", h_q, 32'h0012_3456);
        check("drain_t1", t_q, 11);
        tick();
        check("drain_x2", xfer_q, 1);
        check("drain_h2", h_q, 32'h0000_000F);
        check("drain_t2", t_q, 13);
        tick();
        check("drain_empty", ovalid_q, 0);
        $display("stall/drain done");

        // Flush with two ops in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'h0000_0001; in_shamt = 5'd1; in_tag = 5'd20;
        tick();
        check("fl_acc0", acc_q, 1);
        in_tag = 5'd21;
        tick();
        check("fl_acc1", acc_q, 1);
        flush = 1'b1; in_tag = 5'd22;
        tick();
        check("fl_in_ready", iready_q, 0);
        check("fl_accept", acc_q, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_out_valid", ovalid_q, 0);
        n_seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ovalid_q) n_seen++;
        end
        check("fl_no_ghost", n_seen, 0);
        $display("flush done");
        run_vec('{"post_fl", 2'd1, 32'hFFFF_0000, 5'd16, 5'd23, 32'h0000_FFFF});

        // Random scoreboard with a reset pulse mid-stream
        acc_cnt = 0;
        cyc = 0;
        did_rst = 1'b0;
        while (acc_cnt < 10000 && cyc < 60000) begin
            cyc++;
            if (!did_rst && acc_cnt >= 5000) begin
                did_rst = 1'b1;
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
                tick();
                rst = 1'b0;
                sb.delete();
                out_ready = 1'($urandom_range(0, 1));
                tick();
                check("mid_rst_valid", ovalid_q, 0);
                check("mid_rst_h", h_q, 0);
                check("mid_rst_tag", t_q, 0);
                $display("mid-stream reset after %0d ops", acc_cnt);
                continue;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_tag    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (xfer_q) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_h", h_q, e.h);
                    check("sb_tag", t_q, e.tag);
                end
            end
            if (acc_q) begin
                sb.push_back('{model(in_op, in_a, in_shamt), in_tag});
                acc_cnt++;
            end
        end
        check("rand_budget", acc_cnt, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (xfer_q) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_h", h_q, e.h);
                    check("sb_tag", t_q, e.tag);
                end
            end
        end
        check("sb_drained", sb.size(), 0);
        check("end_idle", ovalid_q, 0);
        $display("random ops accepted %0d in %0d cycles", acc_cnt, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
